piso_frame_tx: RTL and testbench
================================

Name: piso_frame_tx

Overview:
- Serialising stage directly downstream of the N-bit parallel holding register (d_ffN).
- Accepts one parallel word through a valid/ready handshake and emits it on a single serial line as a frame: start bit (0), N data bits LSB first, stop bit (1).
- Each serial bit is held for DIV clock cycles, set by an internal bit-period counter.
- Asserts a one-cycle DONE strobe when each frame finishes, so the upstream controller can reload the holding register.

Parameters:
- N, 8, data word width; legal range is 1 or more.
- DIV, 4, clock cycles per serial bit; legal range is 1 or more. DIV=1 means one bit per clock.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- N_RESET  in  1  asynchronous active-low reset.
- D  in  N  parallel word from the upstream register (Q of d_ffN).
- VALID  in  1  D holds a word to send.
- READY  out  1  block can accept a word; high only in IDLE.
- SOUT  out  1  serial line; idle level is 1.
- BUSY  out  1  a frame is in progress (START, DATA or STOP).
- DONE  out  1  one-cycle strobe on the first IDLE cycle after a STOP bit completes.

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous, active-low (N_RESET); it is fixed and not parameterised.
- Reset values while N_RESET=0: state=IDLE, SOUT=1, READY=1, BUSY=0, DONE=0, shift register=0, counters=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-frame: the frame is abandoned. SOUT returns to 1 at once. No DONE is produced for the aborted frame.
- All outputs are registered or decoded from state only. There is no combinational path from D or VALID to any output.
- Handshake: a word is accepted on a rising edge where VALID=1 and READY=1. D is captured into the internal shift register on that edge.
- VALID while BUSY=1 is ignored. D may change freely after acceptance.
- States:
  - IDLE: SOUT=1, READY=1, BUSY=0. On accept, go to START and clear the bit-period counter.
  - START: SOUT=0 for DIV cycles, then go to DATA with bit index=0.
  - DATA: SOUT=shreg[0]. After each DIV cycles, shift right by one and increment the bit index. After N bits, go to STOP.
  - STOP: SOUT=1 for DIV cycles, then go to IDLE with DONE=1 for exactly that first IDLE cycle.
- Bit-period counter: counts 0 to DIV-1 and wraps to 0 at each bit boundary. Width is $clog2(DIV), minimum 1.
- Bit index: counts 0 to N-1. Width is $clog2(N+1).
- Latency: SOUT falls to 0 on the edge that accepts the word, so the start bit is visible in the next cycle.
- Frame length: exactly (N+2)*DIV cycles from acceptance to the IDLE edge.
- Back-to-back frames: VALID=1 in the DONE cycle is accepted on that cycle's edge. The next start bit immediately follows the single IDLE/DONE cycle, so the line gap is 1 cycle of SOUT=1 beyond the stop bit.
- DONE and READY are both high in the DONE cycle. An acceptance and the DONE strobe may share that cycle.
- N=1: a frame is start, one data bit, stop. DIV=1: each state lasts one cycle per bit, with no counter stall.

Test Plan:
- Reset: hold N_RESET=0 and toggle CLK → SOUT=1, READY=1, BUSY=0, DONE=0. Release → outputs unchanged until VALID.
- Basic frame (N=8, DIV=4): D=8'hA5, VALID pulsed 1 cycle → SOUT = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles). BUSY=1 throughout. DONE=1 on cycle 41 only.
- Ignored VALID: during the frame, present D=8'hFF with VALID=1 → serial data still 8'hA5. After DONE, READY=1.
- Back-to-back: VALID held 1 with D=8'h01 then 8'h80 → second start bit begins 1 cycle after the first frame's stop bit ends. Data bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Async reset mid-frame: pull N_RESET=0 during data bit 3, between clock edges → SOUT=1 and BUSY=0 immediately. No DONE. After release, a new frame for 8'h3C transmits correctly.
- DIV=1, N=8 build: D=8'h96 → 10-cycle frame 0,0,1,1,0,1,0,0,1,1. DONE on cycle 11.

Source files
------------

// File: rtl/piso_frame_tx_if.sv
// ---------------------------------------------------------------------------
// piso_frame_tx_if
// Handshake and serial-line bundle between the upstream holding register,
// the serialiser and the downstream line.
//   D      parallel word to send (from d_ffN Q)
//   VALID  D holds a word to send
//   READY  serialiser can accept a word (IDLE only)
//   SOUT   serial line, idle level 1
//   BUSY   a frame is in progress
//   DONE   one-cycle strobe on the first IDLE cycle after a stop bit
// master: upstream controller side; slave: the serialiser.
// ---------------------------------------------------------------------------
interface piso_frame_tx_if #(
    parameter int N = 8
);
    logic [N-1:0] D;
    logic         VALID;
    logic         READY;
    logic         SOUT;
    logic         BUSY;
    logic         DONE;

    modport master (
        output D,
        output VALID,
        input  READY,
        input  SOUT,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  D,
        input  VALID,
        output READY,
        output SOUT,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/piso_frame_tx.sv
// ---------------------------------------------------------------------------
// piso_frame_tx
// Parallel-in serial-out frame transmitter. Accepts one N-bit word over a
// valid/ready handshake and sends it as: start bit (0), N data bits LSB
// first, stop bit (1). Every serial bit lasts DIV clock cycles.
// Ports:
//   CLK      system clock, rising edge
//   N_RESET  asynchronous active-low reset
//   bus      piso_frame_tx_if slave: D/VALID in, READY/SOUT/BUSY/DONE out
// All outputs come straight from flops; D and VALID only reach them
// through a clock edge.
// ---------------------------------------------------------------------------
module piso_frame_tx #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic             CLK,
    input  logic             N_RESET,
    piso_frame_tx_if.slave   bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [IW-1:0]  idx_q,   idx_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic           sout_q,  sout_d;
    logic           ready_q, ready_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic           bit_end_s;

    // Last cycle of the current serial bit period.
    assign bit_end_s = (cnt_q == CNT_MAX);

    // Next-state, counters, shift register and next output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.VALID) begin
                    state_d = START;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ZERO;
                    shreg_d = bus.D;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    cnt_d   = CNT_ZERO;
                    idx_d   = IDX_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_MAX) begin
                        state_d = STOP;
                        idx_d   = IDX_ZERO;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = IDX_ZERO;
                shreg_d = {N{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        case (state_d)
            IDLE:    sout_d = 1'b1;
            START:   sout_d = 1'b0;
            DATA:    sout_d = shreg_d[0];
            STOP:    sout_d = 1'b1;
            default: sout_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            shreg_q <= {N{1'b0}};
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.SOUT  = sout_q;
    assign bus.READY = ready_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_frame_tx
// Scoreboard bench. Stimulus pushes every accepted word into exp_q; an
// independent monitor detects each start bit on SOUT, pops the word and
// compares the captured line against the frame derived from the word.
// A second instance built with DIV=1 covers the one-bit-per-clock case.
// ---------------------------------------------------------------------------
module tb_piso_frame_tx;

    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int L   = (N + 2) * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    piso_frame_tx_if #(.N(N)) ifc ();
    piso_frame_tx_if #(.N(N)) ifc1 ();

    piso_frame_tx #(.N(N), .DIV(DIV)) u_dut (
        .CLK     (clk),
        .N_RESET (rst_n),
        .bus     (ifc)
    );

    piso_frame_tx #(.N(N), .DIV(1)) u_dut1 (
        .CLK     (clk),
        .N_RESET (rst_n),
        .bus     (ifc1)
    );

    int          errors    = 0;
    int          checks    = 0;
    int          cyc       = 0;
    int          accepted  = 0;
    int          completed = 0;
    int          aborted   = 0;
    int          done_seen = 0;
    bit          mon_active = 1'b0;
    logic [7:0]  exp_q[$];
    int          starts[$];

    // monitor scratch
    logic [7:0]  mw;
    logic [63:0] mact, mexp;
    bit          mok, mabort;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line level of cycle c of a frame carrying w, with div cycles per bit.
    function automatic logic ref_bit(logic [7:0] w, int div, int c);
        int b;
        b = c / div;
        if (b == 0) return 1'b0;
        if (b <= N) return w[b-1];
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ifc.DONE === 1'b1) done_seen <= done_seen + 1;
    end

    // Monitor: frame capture and comparison
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ifc.SOUT === 1'b0) begin
                mon_active = 1'b1;
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got start bit expected none at cycle %0d", cyc);
                    mw = 8'h00;
                end else begin
                    mw = exp_q.pop_front();
                end
                mact   = 64'd0;
                mexp   = 64'd0;
                mok    = 1'b1;
                mabort = 1'b0;
                for (int c = 0; c < L; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_n) begin
                        mabort = 1'b1;
                        break;
                    end
                    mact[c] = ifc.SOUT;
                    mexp[c] = ref_bit(mw, DIV, c);
                    if (ifc.BUSY !== 1'b1 || ifc.READY !== 1'b0 || ifc.DONE !== 1'b0) mok = 1'b0;
                end
                if (mabort) begin
                    aborted++;
                end else begin
                    check("frame_bits", mact, mexp);
                    check("busy_ready_during_frame", 64'(mok), 64'd1);
                    @(negedge clk);
                    check("done_cycle_done_ready_busy_sout",
                          {60'd0, ifc.DONE, ifc.READY, ifc.BUSY, ifc.SOUT}, 64'hD);
                    completed++;
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic send(logic [7:0] w);
        int n;
        ifc.D     = w;
        ifc.VALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (ifc.READY !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ifc.READY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got READY=%b expected 1", ifc.READY);
        end else begin
            exp_q.push_back(w);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mon_active || exp_q.size() != 0 || ifc.READY !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] act1, exp1;
    bit          ok1;
    logic [7:0]  rw;
    int          gap;

    // Stimulus
    initial begin
        ifc.D      = 8'h00;
        ifc.VALID  = 1'b0;
        ifc1.D     = 8'h00;
        ifc1.VALID = 1'b0;

        // reset held with clock running
        repeat (3) @(negedge clk);
        check("rst_outputs", {60'd0, ifc.SOUT, ifc.READY, ifc.BUSY, ifc.DONE}, 64'hC);
        check("rst_outputs_div1", {60'd0, ifc1.SOUT, ifc1.READY, ifc1.BUSY, ifc1.DONE}, 64'hC);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_release_idle", {60'd0, ifc.SOUT, ifc.READY, ifc.BUSY, ifc.DONE}, 64'hC);
        end
        @(posedge clk);
        #1;

        // basic frame, then VALID with 8'hFF held while busy
        send(8'hA5);
        ifc.D = 8'hFF;
        repeat (10) @(negedge clk);
        check("ready_low_while_busy", {62'd0, ifc.READY, ifc.BUSY}, 64'h1);
        @(posedge clk);
        #1;
        ifc.VALID = 1'b0;
        wait_idle();

        // back-to-back frames with VALID held
        starts.delete();
        send(8'h01);
        send(8'h80);
        ifc.VALID = 1'b0;
        wait_idle();
        check("b2b_frame_count", 64'(starts.size()), 64'd2);
        if (starts.size() >= 2)
            check("b2b_start_spacing", 64'(starts[1] - starts[0]), 64'(L + 1));

        // asynchronous reset during data bit 3
        send(8'h00);
        ifc.VALID = 1'b0;
        repeat (17) @(posedge clk);
        #3;
        check("sout_before_abort", {63'd0, ifc.SOUT}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_immediate", {60'd0, ifc.SOUT, ifc.READY, ifc.BUSY, ifc.DONE}, 64'hC);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {62'd0, ifc.DONE, ifc.BUSY}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(8'h3C);
        ifc.VALID = 1'b0;
        wait_idle();

        // randomized words with random spacing (0 = back-to-back)
        for (int i = 0; i < 16; i++) begin
            rw  = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            send(rw);
            if (gap > 0) begin
                ifc.VALID = 1'b0;
                wait_idle();
                repeat (gap - 1) @(posedge clk);
                #1;
            end
        end
        ifc.VALID = 1'b0;
        wait_idle();

        // DIV=1 instance
        ifc1.D     = 8'h96;
        ifc1.VALID = 1'b1;
        @(negedge clk);
        check("div1_ready", {63'd0, ifc1.READY}, 64'd1);
        @(posedge clk);
        #1;
        ifc1.VALID = 1'b0;
        act1 = 64'd0;
        exp1 = 64'd0;
        ok1  = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            act1[c] = ifc1.SOUT;
            exp1[c] = ref_bit(8'h96, 1, c);
            if (ifc1.BUSY !== 1'b1 || ifc1.DONE !== 1'b0) ok1 = 1'b0;
        end
        check("div1_frame_bits", act1, exp1);
        check("div1_busy_no_done", 64'(ok1), 64'd1);
        @(negedge clk);
        check("div1_done_cycle", {61'd0, ifc1.DONE, ifc1.READY, ifc1.BUSY}, 64'h6);
        @(negedge clk);
        check("div1_done_one_cycle", {63'd0, ifc1.DONE}, 64'd0);

        // bookkeeping
        repeat (2) @(negedge clk);
        check("frames_completed", 64'(completed), 64'(accepted - aborted));
        check("frames_aborted", 64'(aborted), 64'd1);
        check("done_pulse_count", 64'(done_seen), 64'(completed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
